// File: rtl/uart_parity_engine.sv
// UART parity engine: accumulates frame data parity, checks the received
// parity bit and keeps a saturating count of parity errors.
// Ports:
//   clk, reset    rising-edge clock, synchronous active-high reset
//   parity_mode   000 none, 001 odd, 010 even, 011 mark, 100 space
//   frame_start   starts or restarts a frame and latches parity_mode
//   bit_valid     qualifies bit_in (data LSB first, then parity)
//   clr_err       clears err_count
//   parity_bit    expected parity for the current frame
//   par_ready     high while the parity bit is expected
//   busy          high whenever a frame is in progress
//   frame_done    one-cycle pulse when a frame completes
//   parity_err    pulses with frame_done on a parity mismatch
//   err_count     saturating parity error count
module uart_parity_engine #(
  parameter int DATA_WIDTH = 8,
  parameter int ERR_CNT_W  = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [2:0]           parity_mode,
  input  logic                 frame_start,
  input  logic                 bit_valid,
  input  logic                 bit_in,
  input  logic                 clr_err,
  output logic                 parity_bit,
  output logic                 par_ready,
  output logic                 busy,
  output logic                 frame_done,
  output logic                 parity_err,
  output logic [ERR_CNT_W-1:0] err_count
);

  localparam int CNT_W = $clog2(DATA_WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DATA_WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    PAR  = 2'd2
  } state_t;

  state_t           state, state_d;
  logic             acc, acc_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic [2:0]       mode_q, mode_d;
  logic             done_d, perr_d;
  logic             has_par;

  // Parity decode works only from registered state so parity_bit is
  // stable for the whole parity slot regardless of the input pins.
  always_comb begin
    parity_bit = 1'b0;
    has_par    = 1'b1;
    case (mode_q)
      3'b001:  parity_bit = ~acc;
      3'b010:  parity_bit = acc;
      3'b011:  parity_bit = 1'b1;
      3'b100:  parity_bit = 1'b0;
      default: has_par    = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state;
    acc_d   = acc;
    cnt_d   = cnt;
    mode_d  = mode_q;
    done_d  = 1'b0;
    perr_d  = 1'b0;
    if (frame_start) begin
      // Restart from any state; a coincident bit is dropped.
      state_d = DATA;
      mode_d  = parity_mode;
      acc_d   = 1'b0;
      cnt_d   = '0;
    end else begin
      case (state)
        DATA: begin
          if (bit_valid) begin
            acc_d = acc ^ bit_in;
            cnt_d = cnt + CNT_W'(1);
            if (cnt == LAST) begin
              if (has_par) begin
                state_d = PAR;
              end else begin
                state_d = IDLE;
                done_d  = 1'b1;
              end
            end
          end
        end
        PAR: begin
          if (bit_valid) begin
            state_d = IDLE;
            done_d  = 1'b1;
            perr_d  = (bit_in != parity_bit);
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      acc        <= 1'b0;
      cnt        <= '0;
      mode_q     <= 3'b000;
      frame_done <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      state      <= state_d;
      acc        <= acc_d;
      cnt        <= cnt_d;
      mode_q     <= mode_d;
      frame_done <= done_d;
      parity_err <= perr_d;
    end
  end

  // Clear wins over a coincident increment.
  always_ff @(posedge clk) begin
    if (reset || clr_err) begin
      err_count <= '0;
    end else if (perr_d && (err_count != {ERR_CNT_W{1'b1}})) begin
      err_count <= err_count + ERR_CNT_W'(1);
    end
  end

  assign busy      = (state != IDLE);
  assign par_ready = (state == PAR);

endmodule

// File: tb/tb_uart_parity_engine.sv
// Testbench for uart_parity_engine: table of directed frames plus
// hand-written reset, abort, coincidence and saturation sequences.
module tb_uart_parity_engine;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] parity_mode;
  logic       frame_start;
  logic       bit_valid;
  logic       bit_in;
  logic       clr_err;
  logic       parity_bit;
  logic       par_ready;
  logic       busy;
  logic       frame_done;
  logic       parity_err;
  logic [7:0] err_count;

  int checks = 0;
  int errors = 0;
  int exp_cnt = 0;

  uart_parity_engine #(.DATA_WIDTH(8), .ERR_CNT_W(8)) dut (
    .clk         (clk),
    .reset       (reset),
    .parity_mode (parity_mode),
    .frame_start (frame_start),
    .bit_valid   (bit_valid),
    .bit_in      (bit_in),
    .clr_err     (clr_err),
    .parity_bit  (parity_bit),
    .par_ready   (par_ready),
    .busy        (busy),
    .frame_done  (frame_done),
    .parity_err  (parity_err),
    .err_count   (err_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] mode;
    logic [7:0] data;
    logic       has_par;
    logic       exp_pbit;
    logic       par_in;
    logic       exp_err;
  } vec_t;

  vec_t vecs [8];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic start(input logic [2:0] m);
    parity_mode = m;
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
  endtask

  task automatic send(input logic b);
    bit_valid = 1'b1;
    bit_in    = b;
    step();
    bit_valid = 1'b0;
    bit_in    = 1'b0;
  endtask

  task automatic send_data(input logic [7:0] d, input int n);
    for (int i = 0; i < n; i++) send(d[i]);
  endtask

  initial begin
    vecs[0] = '{3'b010, 8'h17, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{3'b001, 8'h0F, 1'b1, 1'b1, 1'b0, 1'b1};
    vecs[2] = '{3'b000, 8'hAF, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[3] = '{3'b011, 8'hA9, 1'b1, 1'b1, 1'b1, 1'b0};
    vecs[4] = '{3'b100, 8'hA9, 1'b1, 1'b0, 1'b1, 1'b1};
    vecs[5] = '{3'b010, 8'h01, 1'b1, 1'b1, 1'b1, 1'b0};
    vecs[6] = '{3'b001, 8'hFE, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[7] = '{3'b111, 8'h55, 1'b0, 1'b0, 1'b0, 1'b0};

    reset       = 1'b1;
    parity_mode = 3'b000;
    frame_start = 1'b0;
    bit_valid   = 1'b0;
    bit_in      = 1'b0;
    clr_err     = 1'b0;
    step();
    step();
    chk("rst_busy", busy, 0);
    chk("rst_done", frame_done, 0);
    chk("rst_perr", parity_err, 0);
    chk("rst_pbit", parity_bit, 0);
    chk("rst_prdy", par_ready, 0);
    chk("rst_cnt", err_count, 0);
    reset = 1'b0;
    step();

    // Table of complete frames.
    for (int v = 0; v < 8; v++) begin
      start(vecs[v].mode);
      chk($sformatf("v%0d_busy", v), busy, 1);
      send_data(vecs[v].data, 8);
      if (vecs[v].has_par) begin
        chk($sformatf("v%0d_prdy", v), par_ready, 1);
        chk($sformatf("v%0d_pbit", v), parity_bit, vecs[v].exp_pbit);
        chk($sformatf("v%0d_early", v), frame_done, 0);
        send(vecs[v].par_in);
      end
      if (vecs[v].exp_err) exp_cnt++;
      chk($sformatf("v%0d_prdy_off", v), par_ready, 0);
      chk($sformatf("v%0d_done", v), frame_done, 1);
      chk($sformatf("v%0d_perr", v), parity_err, vecs[v].exp_err);
      chk($sformatf("v%0d_cnt", v), err_count, exp_cnt);
      chk($sformatf("v%0d_idle", v), busy, 0);
      step();
      chk($sformatf("v%0d_done_pulse", v), frame_done, 0);
      chk($sformatf("v%0d_perr_pulse", v), parity_err, 0);
    end

    // Reset in the middle of a frame overrides everything.
    start(3'b011);
    send_data(8'hFF, 3);
    reset = 1'b1;
    step();
    reset = 1'b0;
    exp_cnt = 0;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_cnt", err_count, 0);
    chk("mid_rst_pbit", parity_bit, 0);
    chk("mid_rst_done", frame_done, 0);
    send(1'b1);
    chk("idle_bit_ignored", busy, 0);
    chk("idle_bit_nodone", frame_done, 0);

    // Abort after 3 bits, then a full even frame.
    start(3'b010);
    send_data(8'hFF, 3);
    start(3'b010);
    chk("abort_nodone", frame_done, 0);
    chk("abort_busy", busy, 1);
    send_data(8'h17, 7);
    chk("abort_cnt7", par_ready, 0);
    send(1'b0);
    chk("abort_prdy", par_ready, 1);
    chk("abort_pbit", parity_bit, 0);
    send(1'b0);
    chk("abort_done", frame_done, 1);
    chk("abort_perr", parity_err, 0);

    // frame_start with a coincident bit; later mode changes ignored.
    start(3'b010);
    send_data(8'h00, 2);
    parity_mode = 3'b010;
    frame_start = 1'b1;
    bit_valid   = 1'b1;
    bit_in      = 1'b1;
    step();
    frame_start = 1'b0;
    bit_valid   = 1'b0;
    parity_mode = 3'b001;
    send_data(8'h01, 7);
    chk("coinc_cnt7", par_ready, 0);
    chk("coinc_nodone", frame_done, 0);
    send(1'b0);
    chk("coinc_prdy", par_ready, 1);
    chk("mode_latched", parity_bit, 1);
    send(1'b1);
    chk("coinc_done", frame_done, 1);
    chk("coinc_perr", parity_err, 0);
    chk("coinc_cnt", err_count, 0);

    // 256 odd-parity error frames saturate the counter at 255.
    for (int f = 0; f < 256; f++) begin
      start(3'b001);
      send_data(8'h00, 8);
      send(1'b0);
    end
    chk("sat_perr", parity_err, 1);
    chk("sat_cnt", err_count, 255);
    start(3'b001);
    send_data(8'h00, 8);
    clr_err = 1'b1;
    send(1'b0);
    clr_err = 1'b0;
    chk("clr_win_perr", parity_err, 1);
    chk("clr_win_cnt", err_count, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
